// File: rtl/delay_tap_pkg.sv
// delay_tap_pkg: shared state encoding and tap depth table for delay_tap_ctrl
package delay_tap_pkg;
   typedef enum logic [1:0] {ST_CLEAR = 2'd0, ST_FILL = 2'd1, ST_RUN = 2'd2} state_t;
   localparam int MAX_DELAY = 90;
   function automatic int DELAY_TABLE(input int i, input int d0, input int d1, input int d2, input int d3);
      return (i == 0) ? d0 : (i == 1) ? d1 : (i == 2) ? d2 : d3;
   endfunction
endpackage

// File: rtl/delay_tap_mux.sv
// delay_tap_mux: registered NUM_TAPS:1 output mux with valid qualification
module delay_tap_mux #(
   parameter int NUM_TAPS = 4,
   parameter int DATA_W = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         adv,
   input  logic                         qual,
   input  logic [1:0]                   sel,
   input  logic [NUM_TAPS*DATA_W-1:0]   tap_data,
   output logic [DATA_W-1:0]            out_data,
   output logic                         out_valid
);
   logic adv_d;
   logic [DATA_W-1:0] pick;
   assign pick = tap_data[int'(sel)*DATA_W +: DATA_W];
   // Wait one cycle after an advance so the shifted tap is sampled; unqualified data reads as zero
   always_ff @(posedge clk) begin
      if (rst) begin
         adv_d <= 1'b0;
         out_valid <= 1'b0;
         out_data <= '0;
      end else begin
         adv_d <= adv;
         out_valid <= adv_d & qual;
         out_data <= (adv_d & qual) ? pick : '0;
      end
   end
endmodule

// File: rtl/delay_tap_ctrl.sv
// delay_tap_ctrl: clear/fill/run sequencer and tap selector for a bank of delay lines (optional DELAY_TAP_SWITCH_BLANK_EN)
module delay_tap_ctrl
   import delay_tap_pkg::*;
#(
   parameter int NUM_TAPS = 4,
   parameter int DATA_W = 8,
   parameter int DELAY0 = 30,
   parameter int DELAY1 = 45,
   parameter int DELAY2 = 60,
   parameter int DELAY3 = MAX_DELAY,
   parameter int CNT_W = 7,
   parameter int GAP = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid,
   input  logic [NUM_TAPS*DATA_W-1:0]   tap_data,
   input  logic                         cfg_valid,
   input  logic [1:0]                   cfg_sel,
   input  logic                         cfg_clr,
   output logic                         cfg_ready,
   output logic                         cfg_err,
   output logic                         line_en,
   output logic                         line_clr,
   output logic [DATA_W-1:0]            out_data,
   output logic                         out_valid,
   output logic [1:0]                   sel_cur,
   output logic                         busy
);
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(DELAY3);
   state_t state;
   logic [CNT_W-1:0] fill_cnt, fill_nxt;
   logic [1:0] sel_nxt;
   logic accept, sel_ok, qual, adv_q;

   function automatic logic [CNT_W-1:0] depth(input logic [1:0] s);
      return CNT_W'(DELAY_TABLE(int'(s), DELAY0, DELAY1, DELAY2, DELAY3));
   endfunction

   assign cfg_ready = (state != ST_CLEAR);
   assign line_clr = (state == ST_CLEAR);
   assign line_en = in_valid & cfg_ready;
   assign accept = cfg_valid & cfg_ready;
   assign sel_ok = int'(cfg_sel) < NUM_TAPS;
   assign sel_nxt = (accept & sel_ok) ? cfg_sel : sel_cur;
   assign fill_nxt = (line_en && fill_cnt < MAX_CNT) ? fill_cnt + CNT_W'(1) : fill_cnt;
   assign qual = fill_cnt >= depth(sel_cur);

`ifdef DELAY_TAP_SWITCH_BLANK_EN
   localparam int BW = $clog2(GAP + 1);
   logic [BW-1:0] blank_cnt;
   logic sw;
   assign sw = accept & sel_ok & (cfg_sel != sel_cur);
   assign adv_q = line_en & ~sw & (blank_cnt == '0);
   assign busy = (state != ST_RUN) | (blank_cnt != '0);
   // Suppress output for the first GAP advances after a tap change; the switch-cycle advance counts as one
   always_ff @(posedge clk) begin
      if (rst || state == ST_CLEAR) blank_cnt <= '0;
      else if (sw) blank_cnt <= BW'(line_en ? GAP - 1 : GAP);
      else if (line_en && blank_cnt != '0) blank_cnt <= blank_cnt - BW'(1);
   end
`else
   assign adv_q = line_en;
   assign busy = (state != ST_RUN);
`endif

   // Sequence clear/fill/run, track fill level since clear and apply accepted tap requests
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_CLEAR;
         sel_cur <= '0;
         fill_cnt <= '0;
         cfg_err <= 1'b0;
      end else begin
         cfg_err <= accept & ~sel_ok;
         sel_cur <= sel_nxt;
         fill_cnt <= (state == ST_CLEAR) ? '0 : fill_nxt;
         state <= (state == ST_CLEAR) ? ST_FILL :
                  (accept & sel_ok & cfg_clr) ? ST_CLEAR :
                  (fill_nxt >= depth(sel_nxt)) ? ST_RUN : ST_FILL;
      end
   end

   delay_tap_mux #(.NUM_TAPS(NUM_TAPS), .DATA_W(DATA_W)) u_mux (
      .clk(clk),
      .rst(rst),
      .adv(adv_q),
      .qual(qual),
      .sel(sel_cur),
      .tap_data(tap_data),
      .out_data(out_data),
      .out_valid(out_valid)
   );
endmodule

// File: tb/tb_delay_tap_ctrl.sv
// tb_delay_tap_ctrl: directed table-driven bench for delay_tap_ctrl with a behavioural delay-line bank
module tb_delay_tap_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic in_valid = 1'b1;
   logic cfg_valid = 1'b0, cfg_clr = 1'b0;
   logic [1:0] cfg_sel = 2'd0;
   logic cv3 = 1'b0, cc3 = 1'b0;
   logic [1:0] cs3 = 2'd0;
   logic [31:0] tap_bus;
   logic cfg_ready, cfg_err, line_en, line_clr, out_valid, busy;
   logic [7:0] out_data;
   logic [1:0] sel_cur;
   logic cfg_ready3, cfg_err3, line_en3, line_clr3, out_valid3, busy3;
   logic [7:0] out_data3;
   logic [1:0] sel_cur3;

   always #5 clk = ~clk;

   delay_tap_ctrl dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .tap_data(tap_bus),
      .cfg_valid(cfg_valid), .cfg_sel(cfg_sel), .cfg_clr(cfg_clr),
      .cfg_ready(cfg_ready), .cfg_err(cfg_err), .line_en(line_en), .line_clr(line_clr),
      .out_data(out_data), .out_valid(out_valid), .sel_cur(sel_cur), .busy(busy)
   );

   delay_tap_ctrl #(.NUM_TAPS(3)) dut3 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .tap_data(tap_bus[23:0]),
      .cfg_valid(cv3), .cfg_sel(cs3), .cfg_clr(cc3),
      .cfg_ready(cfg_ready3), .cfg_err(cfg_err3), .line_en(line_en3), .line_clr(line_clr3),
      .out_data(out_data3), .out_valid(out_valid3), .sel_cur(sel_cur3), .busy(busy3)
   );

   // Delay-line bank driven by the main DUT strobes; each pushed sample is a running 8-bit count
   localparam int DEP [4] = '{30, 45, 60, 90};
   logic [7:0] hist [0:1023];
   int len = 0;
   logic [7:0] gval = 8'd0;
   always @(posedge clk) begin
      if (line_clr) len <= 0;
      else if (line_en) begin
         hist[len] <= gval + 8'd1;
         gval <= gval + 8'd1;
         len <= len + 1;
      end
   end
   always_comb begin
      tap_bus = '0;
      for (int i = 0; i < 4; i++) tap_bus[i*8 +: 8] = (len >= DEP[i]) ? hist[len-DEP[i]] : 8'd0;
   end

   int total = 0, bad = 0;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic cyc(input logic iv, input logic cv, input logic [1:0] cs, input logic cc);
      in_valid = iv;
      cfg_valid = cv;
      cfg_sel = cs;
      cfg_clr = cc;
      @(posedge clk);
      @(negedge clk);
      cfg_valid = 1'b0;
      cfg_clr = 1'b0;
   endtask

   typedef struct {
      int n;
      logic cv;
      logic [1:0] cs;
      logic cc;
      logic ev;
      logic [7:0] ed;
      logic [1:0] es;
      logic ev3;
      string name;
   } vec_t;
   vec_t tbl [15];

   initial begin
      tbl[0]  = '{30, 1'b0, 2'd0, 1'b0, 1'b0, 8'd0,  2'd0, 1'b0, "fill_tap0"};
      tbl[1]  = '{1,  1'b0, 2'd0, 1'b0, 1'b1, 8'd1,  2'd0, 1'b1, "first_tap0"};
      tbl[2]  = '{10, 1'b0, 2'd0, 1'b0, 1'b1, 8'd11, 2'd0, 1'b1, "run_tap0"};
      tbl[3]  = '{9,  1'b0, 2'd0, 1'b0, 1'b1, 8'd20, 2'd0, 1'b1, "adv50"};
      tbl[4]  = '{1,  1'b1, 2'd3, 1'b0, 1'b1, 8'd21, 2'd3, 1'b1, "sel3_req"};
      tbl[5]  = '{1,  1'b0, 2'd0, 1'b0, 1'b0, 8'd0,  2'd3, 1'b1, "sel3_fill"};
      tbl[6]  = '{38, 1'b0, 2'd0, 1'b0, 1'b0, 8'd0,  2'd3, 1'b1, "fill89"};
      tbl[7]  = '{1,  1'b1, 2'd1, 1'b0, 1'b1, 8'd1,  2'd1, 1'b1, "tap3_first"};
      tbl[8]  = '{1,  1'b0, 2'd0, 1'b0, 1'b1, 8'd47, 2'd1, 1'b1, "sel1_nogap"};
      tbl[9]  = '{5,  1'b0, 2'd0, 1'b0, 1'b1, 8'd52, 2'd1, 1'b1, "sel1_run"};
      tbl[10] = '{1,  1'b1, 2'd1, 1'b1, 1'b1, 8'd53, 2'd1, 1'b1, "clear"};
      tbl[11] = '{1,  1'b0, 2'd0, 1'b0, 1'b1, 8'd54, 2'd1, 1'b1, "clear_tail"};
      tbl[12] = '{1,  1'b0, 2'd0, 1'b0, 1'b0, 8'd0,  2'd1, 1'b1, "clear_drop"};
      tbl[13] = '{44, 1'b0, 2'd0, 1'b0, 1'b0, 8'd0,  2'd1, 1'b1, "refill44"};
      tbl[14] = '{1,  1'b0, 2'd0, 1'b0, 1'b1, 8'd99, 2'd1, 1'b1, "refill_first"};
      @(negedge clk);
      @(negedge clk);
      chk("rst.out_valid", out_valid, 0);
      chk("rst.out_data", out_data, 0);
      chk("rst.sel_cur", sel_cur, 0);
      chk("rst.cfg_err", cfg_err, 0);
      chk("rst.line_clr", line_clr, 1);
      chk("rst.line_en", line_en, 0);
      chk("rst.cfg_ready", cfg_ready, 0);
      chk("rst.busy", busy, 1);
      rst = 1'b0;
      cyc(1'b1, 1'b0, 2'd0, 1'b0);
      chk("start.line_clr", line_clr, 0);
      chk("start.line_en", line_en, 1);
      chk("start.cfg_ready", cfg_ready, 1);
      chk("start.busy", busy, 1);
      foreach (tbl[k]) begin
         for (int j = 0; j < tbl[k].n; j++)
            cyc(1'b1, (j == 0) ? tbl[k].cv : 1'b0, tbl[k].cs, (j == 0) ? tbl[k].cc : 1'b0);
         chk($sformatf("%s.out_valid", tbl[k].name), out_valid, tbl[k].ev);
         chk($sformatf("%s.out_data", tbl[k].name), out_data, tbl[k].ed);
         chk($sformatf("%s.sel_cur", tbl[k].name), sel_cur, tbl[k].es);
         chk($sformatf("%s.out_valid3", tbl[k].name), out_valid3, tbl[k].ev3);
         if (tbl[k].name == "clear") begin
            chk("clear.line_clr", line_clr, 1);
            chk("clear.line_en", line_en, 0);
            chk("clear.cfg_ready", cfg_ready, 0);
            chk("clear.busy", busy, 1);
         end
      end
      rst = 1'b1;
      cyc(1'b1, 1'b0, 2'd0, 1'b0);
      chk("midrst.out_valid", out_valid, 0);
      chk("midrst.out_data", out_data, 0);
      chk("midrst.sel_cur", sel_cur, 0);
      chk("midrst.line_clr", line_clr, 1);
      chk("midrst.line_en", line_en, 0);
      chk("midrst.busy", busy, 1);
      chk("midrst.out_valid3", out_valid3, 0);
      rst = 1'b0;
      repeat (35) cyc(1'b1, 1'b0, 2'd0, 1'b0);
      chk("err.pre_ready3", cfg_ready3, 1);
      chk("err.pre_busy3", busy3, 0);
      chk("err.pre_err3", cfg_err3, 0);
      cv3 = 1'b1;
      cs3 = 2'd3;
      cyc(1'b1, 1'b0, 2'd0, 1'b0);
      cv3 = 1'b0;
      cs3 = 2'd0;
      chk("err.pulse", cfg_err3, 1);
      chk("err.sel_cur3", sel_cur3, 0);
      chk("err.out_valid3", out_valid3, 1);
      chk("err.main_err", cfg_err, 0);
      cyc(1'b1, 1'b0, 2'd0, 1'b0);
      chk("err.pulse_end", cfg_err3, 0);
      chk("err.sel_after", sel_cur3, 0);
      chk("err.valid_after", out_valid3, 1);
      chk("err.busy_after", busy3, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/delay_tap_ctrl.md
Name: delay_tap_ctrl

Overview:
- Controller that sequences a bank of fixed-depth 8-bit delay lines (default taps 30/45/60/90) sharing one input stream.
- Issues the line advance and clear strobes and tracks fill level since the last clear.
- Owns tap selection through a valid/ready config port; presents a registered, qualified output (out_valid only once the selected line holds real samples).
- Sits between the top-level pin wrapper and the delay-line instances.

Parameters:
- NUM_TAPS, 4, number of delay lines (2..4)
- DATA_W, 8, sample width
- DELAY0, 30, depth of tap 0 in samples
- DELAY1, 45, depth of tap 1
- DELAY2, 60, depth of tap 2
- DELAY3, 90, depth of tap 3 (maximum depth, MAX_DELAY)
- CNT_W, 7, fill counter width; must satisfy 2^CNT_W > MAX_DELAY
- GAP, 4, blanking length in samples (used only with the optional feature)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  new input sample present this cycle
- tap_data  in  NUM_TAPS*DATA_W  delay-line outputs; tap i in bits [i*DATA_W +: DATA_W]
- cfg_valid  in  1  config request
- cfg_sel  in  2  requested tap index
- cfg_clr  in  1  with an accepted request: clear all lines
- cfg_ready  out  1  config accepted when cfg_valid&cfg_ready
- cfg_err  out  1  one-cycle pulse: request rejected (cfg_sel >= NUM_TAPS)
- line_en  out  1  advance all delay lines this cycle
- line_clr  out  1  clear all delay lines this cycle
- out_data  out  DATA_W  selected sample, registered
- out_valid  out  1  out_data valid this cycle
- sel_cur  out  2  active tap
- busy  out  1  high in CLEAR or FILL

Behaviour:
- Reset: state CLEAR, sel_cur=0, fill_cnt=0, out_data=0, out_valid=0, cfg_err=0, adv_d=0.
- FSM states:
  - CLEAR: line_clr=1, line_en=0, cfg_ready=0, fill_cnt<=0. Lasts exactly one cycle, then goes to FILL.
  - FILL: entered while fill_cnt < DELAY[sel_cur]. Goes to RUN when fill_cnt >= DELAY[sel_cur].
  - RUN: steady state. Goes to FILL on a tap switch where fill_cnt < DELAY[new sel]. Goes to CLEAR on an accepted request with cfg_clr=1.
- line_en = in_valid & (state != CLEAR). Samples arriving during CLEAR are dropped.
- fill_cnt increments on each line_en and saturates at MAX_DELAY; it never wraps.
- Config handshake:
  - cfg_ready=1 in FILL and RUN.
  - Accepted request with cfg_sel < NUM_TAPS: sel_cur takes the new value at the next edge. If cfg_clr=1, go to CLEAR. Otherwise go to FILL or RUN by comparing the updated fill_cnt against DELAY[new].
  - Accepted request with cfg_sel >= NUM_TAPS: cfg_err pulses for one cycle; sel_cur, state and clear are unchanged.
  - Request with the same tap and cfg_clr=0: no state change.
- Output pipeline:
  - adv_d <= line_en.
  - Next cycle: out_data <= tap_data[sel_cur]; out_valid <= adv_d & (fill_cnt >= DELAY[sel_cur]).
  - Latency: in_valid at cycle t gives out_valid at t+2.
  - When out_valid=0, out_data holds 0.
- Simultaneous accepted cfg and in_valid: the sample is counted and advanced. The output qualification in the following cycle uses the new sel_cur.
- Switching to a shorter tap at or below fill_cnt: no blanking; data continues with no gap.
- rst mid-operation overrides everything and returns to the reset values above.

Optional Feature:
- Macro DELAY_TAP_SWITCH_BLANK_EN.
- Defined: after any accepted tap change (new sel != sel_cur), out_valid is forced 0 for the next GAP line_en advances. This is tracked by a blank counter, and busy stays high while the counter is nonzero. A clear also zeroes the counter.
- Undefined: no blanking; GAP is ignored.

Decomposition:
- Shared package delay_tap_pkg holds:
  - state encoding constants ST_CLEAR, ST_FILL, ST_RUN
  - the DELAY_TABLE constant function returning DELAY[i]
  - MAX_DELAY
- One natural sub-module: delay_tap_mux, the registered NUM_TAPS:1 output mux with valid qualification.

Test Plan:
- Reset, then in_valid held high, sel 0 → line_clr high for 1 cycle only. First out_valid is 2 cycles after the 30th line_en; out_data equals sample #1.
- After 50 advances on tap 0, request sel=3 → state FILL, out_valid low until fill_cnt reaches 90, then sample #1 appears.
- At fill_cnt=90 on tap 3, request sel=1 → no gap in out_valid; out_data equals the value 45 samples back.
- cfg_sel=3 with NUM_TAPS=3 → cfg_err pulses once; sel_cur and out_valid are unchanged.
- cfg_clr=1 with an in_valid on the same cycle → one CLEAR cycle with line_en=0; fill_cnt restarts from 0 and out_valid drops.
- rst asserted mid-RUN for 1 cycle → all outputs return to their reset values. With DELAY_TAP_SWITCH_BLANK_EN defined, a tap switch at full fill blanks exactly 4 samples.
